// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM, and a
// single-entry output register with a valid/ack handshake plus error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BRK   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_s_rx;
  logic w_half;
  logic w_full;
  logic w_cnt_clr;
  logic w_idx_clr;
  logic w_shift;
  logic w_load;
  logic w_ferr;

  assign w_s_rx = r_sync2;
  assign w_half = (r_cnt == HALF_LAST);
  assign w_full = (r_cnt == FULL_LAST);

  // Synchroniser flops reset high so a reset line never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_s_rx) w_next = S_START;
      S_START: if (w_half) w_next = w_s_rx ? S_IDLE : S_DATA;
      S_DATA:  if (w_full && (r_idx == 3'd7)) w_next = S_STOP;
      // Leaving at mid stop bit lets a start edge right after the stop bit be caught.
      S_STOP:  if (w_full) w_next = w_s_rx ? S_IDLE : S_BRK;
      S_BRK:   if (w_s_rx) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr = 1'b0;
    w_idx_clr = 1'b0;
    w_shift   = 1'b0;
    w_load    = 1'b0;
    w_ferr    = 1'b0;
    case (r_state)
      S_IDLE:  w_cnt_clr = 1'b1;
      S_START: begin
        w_cnt_clr = w_half;
        w_idx_clr = w_half;
      end
      S_DATA: begin
        w_cnt_clr = w_full;
        w_shift   = w_full;
      end
      S_STOP: begin
        w_cnt_clr = w_full;
        w_load    = w_full && w_s_rx;
        w_ferr    = w_full && !w_s_rx;
      end
      S_BRK:   w_cnt_clr = 1'b1;
      default: w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (w_idx_clr) begin
        r_idx <= '0;
      end else if (w_shift) begin
        r_shift[r_idx] <= w_s_rx;
        r_idx          <= r_idx + 3'd1;
      end
    end
  end

  // Handshake: rx_valid rises when a good byte loads and stays high until a
  // cycle with rx_ack; a load in that same cycle wins and is not an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_load && r_rx_valid && !rx_ack;
      if (w_load) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven from a bit-level model,
// received bytes checked against an expected queue.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] state_dbg;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_mem [0:63];
  int         got_cyc [0:63];
  int         n_load = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
    if (overrun === 1'b1) n_ovr <= n_ovr + 1;
    if ((rx_valid === 1'b1 && prev_valid !== 1'b1) || overrun === 1'b1) begin
      got_mem[n_load[5:0]] <= rx_data;
      got_cyc[n_load[5:0]] <= cyc;
      n_load <= n_load + 1;
    end
  end

  // ---------------- ack driver ----------------
  logic auto_ack = 1'b0;
  logic manual_ack = 1'b0;

  initial begin
    rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      rx_ack = auto_ack ? rx_valid : manual_ack;
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         rd_idx = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic send_good(input logic [7:0] d);
    exp_q.push_back(d);
    send_frame(d, 1'b1);
  endtask

  task automatic wait_loads(input string tag, input int target);
    logic [7:0] e;
    for (int i = 0; i < 3000 && n_load < target; i++) @(negedge clk);
    check({tag, "_count"}, n_load, target);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, got_mem[rd_idx[5:0]], e);
      rd_idx++;
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  int t0;
  int lat;
  int ferr0;
  int ovr0;
  int load0;
  int rand_gap;

  initial begin
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state_dbg, 3'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // T1: single frame 0x27, latency from falling edge
    t0 = cyc;
    send_good(8'h27);
    wait_loads("t1", 1);
    lat = got_cyc[0] - t0;
    check("t1_latency_in_window", (lat >= 154 && lat <= 156), 1'b1);
    check("t1_valid", rx_valid, 1'b1);
    check("t1_flags", {n_ferr[3:0], n_ovr[3:0]}, 8'h00);
    pulse_ack();
    check("t1_ack_clears", rx_valid, 1'b0);

    // T2: 3-cycle glitch is rejected at mid start bit
    load0 = n_load;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_busy_seen", busy, 1'b1);
    rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check("t2_state_idle", state_dbg, 3'd0);
    check("t2_busy_low", busy, 1'b0);
    check("t2_no_load", n_load, load0);
    check("t2_no_ferr", n_ferr, 0);

    // T3: bad stop bit with the line held low, then recovery
    ferr0 = n_ferr;
    send_frame(8'hA5, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("t3_ferr_once", n_ferr - ferr0, 1);
    check("t3_state_brk", state_dbg, 3'd4);
    check("t3_valid", rx_valid, 1'b0);
    check("t3_data_kept", rx_data, 8'h27);
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("t3_idle_again", state_dbg, 3'd0);
    send_good(8'h3C);
    wait_loads("t3", load0 + 1);
    check("t3_rx_data", rx_data, 8'h3C);
    pulse_ack();

    // T4: two frames without ack -> one overrun, newest byte kept
    ovr0 = n_ovr;
    send_good(8'h11);
    send_good(8'h22);
    wait_loads("t4", load0 + 3);
    check("t4_ovr_once", n_ovr - ovr0, 1);
    check("t4_rx_data", rx_data, 8'h22);
    check("t4_valid", rx_valid, 1'b1);
    @(negedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    check("t4_ack_next_cycle", rx_valid, 1'b0);

    // T5: reset during data bit 4 of 0xFF
    ferr0 = n_ferr;
    ovr0 = n_ovr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    check("t5_in_data", state_dbg, 3'd2);
    reset = 1'b0;
    #1;
    check("t5_rst_data", rx_data, 8'h00);
    check("t5_rst_valid", rx_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_state", state_dbg, 3'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    load0 = n_load;
    send_good(8'h80);
    wait_loads("t5", load0 + 1);
    check("t5_rx_data", rx_data, 8'h80);
    check("t5_no_flags", {n_ferr - ferr0, n_ovr - ovr0}, 64'd0);
    pulse_ack();

    // T6: back-to-back frames with immediate acks, then random bytes
    auto_ack = 1'b1;
    ferr0 = n_ferr;
    ovr0 = n_ovr;
    load0 = n_load;
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h55);
    for (int i = 0; i < 3; i++) begin
      rand_gap = $urandom_range(0, 5);
      repeat (rand_gap) @(negedge clk);
      send_good(8'($urandom_range(0, 255)));
    end
    wait_loads("t6", load0 + 6);
    check("t6_no_ferr", n_ferr - ferr0, 0);
    check("t6_no_ovr", n_ovr - ovr0, 0);
    repeat (4) @(negedge clk);
    auto_ack = 1'b0;
    check("t6_valid_low", rx_valid, 1'b0);

    // ack with nothing pending is ignored
    pulse_ack();
    check("ack_idle_ignored", rx_valid, 1'b0);
    check("ack_idle_no_load", n_load, load0 + 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
